// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the two-master servant RAM arbiter.
package servant_arb_pkg;

  // Grant one-hot: bit0 = master 0 (CPU), bit1 = master 1 (loader).
  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantM0   = 2'b01;
  localparam logic [1:0] GrantM1   = 2'b10;

  // State codes equal the grant vector, so the state register doubles as the grant flop.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } arb_state_e;

  function automatic logic [1:0] state_grant(input arb_state_e s);
    logic [1:0] g;
    unique case (s)
      StGnt0:  g = GrantM0;
      StGnt1:  g = GrantM1;
      default: g = GrantNone;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/servant_arb_wdog.sv
// Saturating cycle counter that flags a granted transaction stalled for Timeout cycles.
module servant_arb_wdog #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Keep at least one bit so Timeout = 0 (watchdog disabled) still elaborates.
  localparam int unsigned CntW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (Timeout != 0) && (cnt_q == CntW'(Timeout));

endmodule

// File: rtl/servant_arbiter.sv
// Round-robin arbiter letting the CPU bus and a loader/debug master share servant_ram,
// one classic Wishbone transaction at a time, with a stall watchdog.
module servant_arbiter
  import servant_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned AW      = 32
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  // Master 0 (CPU)
  input  logic [AW-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_cyc,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  output logic          o_wb_m0_err,
  // Master 1 (loader)
  input  logic [AW-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_cyc,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic          o_wb_m1_err,
  // Slave (RAM)
  output logic [AW-1:0] o_wb_s_adr,
  output logic [31:0]   o_wb_s_dat,
  output logic [3:0]    o_wb_s_sel,
  output logic          o_wb_s_we,
  output logic          o_wb_s_cyc,
  input  logic [31:0]   i_wb_s_rdt,
  input  logic          i_wb_s_ack,
  output logic [1:0]    o_grant
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;  // master that finished most recently; loses the next tie

  logic sel_m1;
  logic gnt_act;
  logic m_cyc;
  logic fwd_ack;
  logic tout;
  logic wd_expired;

  servant_arb_wdog #(
    .Timeout (TIMEOUT)
  ) u_wdog (
    .clk_i     (i_wb_clk),
    .rst_i     (i_wb_rst),
    .clr_i     (~gnt_act),
    .en_i      (gnt_act),
    .expired_o (wd_expired)
  );

  // Granted-master selection and transaction end conditions; ack beats a same-cycle timeout.
  always_comb begin
    sel_m1  = (state_q == StGnt1);
    gnt_act = (state_q != StIdle);
    m_cyc   = sel_m1 ? i_wb_m1_cyc : i_wb_m0_cyc;
    fwd_ack = gnt_act & i_wb_s_ack & m_cyc;
    tout    = gnt_act & m_cyc & ~i_wb_s_ack & wd_expired;
  end

  // Request mux toward the RAM and response steering back to the masters.
  always_comb begin
    o_wb_s_adr  = '0;
    o_wb_s_dat  = '0;
    o_wb_s_sel  = '0;
    o_wb_s_we   = 1'b0;
    o_wb_s_cyc  = 1'b0;
    o_wb_m0_ack = 1'b0;
    o_wb_m1_ack = 1'b0;
    o_wb_m0_err = 1'b0;
    o_wb_m1_err = 1'b0;
    o_wb_m0_rdt = i_wb_s_rdt;
    o_wb_m1_rdt = i_wb_s_rdt;
    if (gnt_act) begin
      o_wb_s_adr  = sel_m1 ? i_wb_m1_adr : i_wb_m0_adr;
      o_wb_s_dat  = sel_m1 ? i_wb_m1_dat : i_wb_m0_dat;
      o_wb_s_sel  = sel_m1 ? i_wb_m1_sel : i_wb_m0_sel;
      o_wb_s_we   = sel_m1 ? i_wb_m1_we  : i_wb_m0_we;
      o_wb_s_cyc  = m_cyc & ~tout;
      o_wb_m0_ack = fwd_ack & ~sel_m1;
      o_wb_m1_ack = fwd_ack & sel_m1;
      o_wb_m0_err = tout & ~sel_m1;
      o_wb_m1_err = tout & sel_m1;
    end
  end

  // Next state: round-robin grant from idle; every grant returns to idle (one-cycle bubble).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (i_wb_m0_cyc && i_wb_m1_cyc) begin
          state_d = last_q ? StGnt0 : StGnt1;
        end else if (i_wb_m0_cyc) begin
          state_d = StGnt0;
        end else if (i_wb_m1_cyc) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (fwd_ack || !m_cyc || tout) begin
          state_d = StIdle;
          last_d  = sel_m1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and round-robin pointer; last = 1 out of reset so master 0 wins the first tie.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign o_grant = state_grant(state_q);

endmodule

// File: doc/servant_arbiter.md
# servant_arbiter

Two-master Wishbone arbiter sharing the single-port `servant_ram` between the CPU memory bus and a second master (loader/debug DMA). Grants one classic-Wishbone transaction at a time, round-robin when both masters request. Includes a watchdog that terminates a stalled transaction with an error strobe. Sits between `servile`'s `wb_mem` port plus the second master and `servant_ram`.

## Interface
- `TIMEOUT`, default 15: max cycles a granted transaction waits for slave ack; 0 disables the watchdog.
- `AW`, default 32: address width on all ports.
- `i_wb_clk` in, 1: system clock; all logic on its rising edge.
- `i_wb_rst` in, 1: reset, synchronous, active-high.
- `i_wb_m0_adr` in, AW / `i_wb_m0_dat` in, 32 / `i_wb_m0_sel` in, 4 / `i_wb_m0_we` in, 1 / `i_wb_m0_cyc` in, 1: master 0 (CPU) request.
- `o_wb_m0_rdt` out, 32 / `o_wb_m0_ack` out, 1 / `o_wb_m0_err` out, 1: master 0 response.
- `i_wb_m1_*`, `o_wb_m1_*`: master 1 (loader), identical widths.
- `o_wb_s_adr` out, AW / `o_wb_s_dat` out, 32 / `o_wb_s_sel` out, 4 / `o_wb_s_we` out, 1 / `o_wb_s_cyc` out, 1: slave (RAM) request.
- `i_wb_s_rdt` in, 32 / `i_wb_s_ack` in, 1: slave response.
- `o_grant` out, 2: one-hot registered grant (bit0 = m0, bit1 = m1); 2'b00 when idle.

## Operation
- States: IDLE, GNT0, GNT1. Reset → IDLE, `last` pointer = 1 (so m0 wins first tie), watchdog count = 0.
- IDLE: one `cyc` high → grant that master. Both high → grant master ≠ `last`. Neither → stay.
- GNTn: slave request fields = master n's fields; `o_wb_s_cyc` = `i_wb_mn_cyc`. Non-granted master sees ack/err = 0.
- GNTn, `i_wb_s_ack` high → `o_wb_mn_ack` = 1 same cycle (combinational), `last` ← n, next state IDLE.
- GNTn, master drops `cyc` before ack (abort) → IDLE next cycle, no ack forwarded, `last` ← n.
- Watchdog: counts cycles in GNTn without ack. On count reaching `TIMEOUT` (with `TIMEOUT` ≠ 0) → `o_wb_mn_err` = 1 for that one cycle, `o_wb_s_cyc` forced 0 that cycle, `last` ← n, next state IDLE. Ack and timeout in the same cycle → ack wins, no err.
- `i_wb_s_ack` received in IDLE (late ack after abort/timeout) is discarded.
- `o_wb_m0_rdt` = `o_wb_m1_rdt` = `i_wb_s_rdt` (broadcast); validity is qualified by ack only.
- IDLE: all slave outputs 0.

## Timing
- Reset values: `o_grant` = 0; `o_wb_s_cyc`, `o_wb_s_we` = 0; all `ack`/`err` = 0; `o_wb_s_adr`/`dat`/`sel` = 0.
- Grant is registered: `cyc` rises at cycle N with arbiter idle → `o_grant` and `o_wb_s_cyc` at N+1. A one-cycle-latency RAM acks at N+2, and the master ack is also at N+2. Total latency 2 cycles.
- One mandatory IDLE bubble after every completion. A back-to-back master issues its next `cyc` in cycle N+3 at the earliest, or keeps it high, and is re-arbitrated at N+3.
- Reset asserted mid-transaction → IDLE next edge, no ack/err issued. Any pending slave ack is ignored.
- Watchdog counter width is `$clog2(TIMEOUT+1)`, saturating, cleared on every state entry.

## Structure
- Package `servant_arb_pkg`: state enum (IDLE/GNT0/GNT1) and grant one-hot constants.
- Sub-module `servant_arb_wdog`: the timeout counter (clear, enable, `TIMEOUT` compare, expired flag).
- FSM, round-robin pointer and muxing stay in the top.

## Test plan
- Single m0 read: m0 cyc at cycle 0, adr=0x100 → `o_grant`=01 and slave cyc at 1, RAM ack at 2 → `o_wb_m0_ack`=1 at 2, rdt = RAM word, m1 ack stays 0.
- Simultaneous requests after reset: both cyc at 0 → m0 served first (ack at 2), m1 granted at 4, acked at 5. Repeat with both held → strict alternation m0,m1,m0,m1.
- m1 write, sel=4'b0011, dat=0xDEADBEEF → slave sees identical adr/dat/sel/we=1 while `o_grant`=10. Readback by m0 returns 0x????BEEF per sel.
- Stalled slave, TIMEOUT=15: slave never acks → `o_wb_m0_err` single pulse exactly 15 cycles after grant, slave cyc 0 that cycle, IDLE after. Late slave ack at +3 cycles is dropped.
- Abort: m1 drops cyc one cycle after grant → IDLE next cycle, no ack/err. Pending m0 is granted the following cycle.
- Reset mid-grant: assert `i_wb_rst` while in GNT1 → all outputs 0 next edge. The next tie goes to m0.
